// File: rtl/bloom_pkg.sv
// Shared types and hash constants for the bloom filter unit.
package bloom_pkg;

    // Command encoding carried on op_i
    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_INSERT = 2'b01,
        OP_CHECK  = 2'b10,
        OP_CLEAR  = 2'b11
    } bloom_op_e;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_HASH  = 2'b01,
        ST_CLEAR = 2'b10,
        ST_RESP  = 2'b11
    } bloom_state_e;

    // Multiplicative hash constant (golden ratio)
    localparam logic [31:0] GOLDEN = 32'h9E3779B1;

    // Per-hash salts; hash i uses SALT[i]
    localparam logic [31:0] SALT [8] = '{
        32'h00000000, 32'h85EBCA6B, 32'hC2B2AE35, 32'h27D4EB2F,
        32'h165667B1, 32'hD3A2646C, 32'hFD7046C5, 32'hB55A4F09
    };

endpackage

// File: rtl/bloom_hash.sv
// Combinational salted multiplicative hash: key, hash select -> array index.
// Kept as its own module so the 32x32 multiplier stays isolated for timing.
module bloom_hash
    import bloom_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic [31:0]      key,
    input  logic [2:0]       sel,
    output logic [IDX_W-1:0] idx
);

    logic [31:0]      prod;
    logic [31-IDX_W:0] unused_low;

    // Low 32 bits of the product; the index is taken from the top bits,
    // which carry the best-mixed result of a multiplicative hash.
    assign prod       = (key ^ SALT[sel]) * GOLDEN;
    assign idx        = prod[31 -: IDX_W];
    assign unused_low = prod[31-IDX_W:0];

endmodule

// File: rtl/bloom_filter_unit.sv
// Bloom-filter responder for the custom-instruction issue logic.
// Accepts INSERT / CHECK / CLEAR / NOP, walks NUM_HASH indices one per cycle
// over a NUM_BITS-bit array and returns a one-cycle response with match flag.
// Optional feature macro: BLOOM_STATS_EN enables the pop_count_o set-bit
// counter; without it pop_count_o is tied to zero.
module bloom_filter_unit
    import bloom_pkg::*;
#(
    parameter int NUM_BITS = 256,
    parameter int NUM_HASH = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          op_valid_i,
    output logic                          op_ready_o,
    input  logic [1:0]                    op_i,
    input  logic [31:0]                   key_i,
    output logic                          resp_valid_o,
    output logic                          resp_match_o,
    output logic [$clog2(NUM_BITS+1)-1:0] pop_count_o
);

    localparam int IDX_W     = $clog2(NUM_BITS);
    localparam int NUM_WORDS = NUM_BITS / 32;
    localparam int WSEL_W    = (IDX_W > 5) ? IDX_W - 5 : 1;
    localparam int CNT_W     = (NUM_WORDS > 8) ? $clog2(NUM_WORDS) : 3;
    localparam int POP_W     = $clog2(NUM_BITS + 1);

    bloom_state_e      state;
    bloom_op_e         op_in;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       key_q;
    logic              ins_q;
    logic              acc;
    logic              accept;

    logic [IDX_W-1:0]  hidx;
    logic [2:0]        hsel;
    logic [WSEL_W-1:0] word_sel;
    logic [4:0]        bit_sel;
    logic [WSEL_W-1:0] clr_sel;
    logic              cur_bit;
    logic              last_hash;
    logic              last_word;
    logic              set_en;
    logic              clr_en;

    logic [31:0]       mem [NUM_WORDS];

    assign op_in  = bloom_op_e'(op_i);
    assign accept = op_valid_i && op_ready_o;

    // The same counter walks hash indices in HASH and words in CLEAR
    assign hsel      = cnt[2:0];
    assign last_hash = (cnt == CNT_W'(NUM_HASH - 1));
    assign last_word = (cnt == CNT_W'(NUM_WORDS - 1));

    bloom_hash #(
        .IDX_W (IDX_W)
    ) u_hash (
        .key (key_q),
        .sel (hsel),
        .idx (hidx)
    );

    // Word select is the index above bit 5; a 32-bit array has a single word
    assign word_sel = WSEL_W'(hidx >> 5);
    assign bit_sel  = hidx[4:0];
    assign clr_sel  = WSEL_W'(cnt);
    assign cur_bit  = mem[word_sel][bit_sel];
    assign set_en   = (state == ST_HASH) && ins_q;
    assign clr_en   = (state == ST_CLEAR);

    // Control FSM with registered handshake and response outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            key_q        <= '0;
            ins_q        <= 1'b0;
            acc          <= 1'b0;
            op_ready_o   <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_match_o <= 1'b0;
        end else begin
            resp_valid_o <= 1'b0;
            resp_match_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_ready_o <= 1'b0;
                        cnt        <= '0;
                        case (op_in)
                            OP_INSERT, OP_CHECK: begin
                                state <= ST_HASH;
                                key_q <= key_i;
                                ins_q <= (op_in == OP_INSERT);
                                acc   <= 1'b1;
                            end
                            OP_CLEAR: begin
                                state <= ST_CLEAR;
                            end
                            default: begin
                                state        <= ST_RESP;
                                resp_valid_o <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_HASH: begin
                    // Accumulate on the pre-set bit value so INSERT reports
                    // whether the key was already present
                    acc <= acc & cur_bit;
                    cnt <= cnt + CNT_W'(1);
                    if (last_hash) begin
                        state        <= ST_RESP;
                        resp_valid_o <= 1'b1;
                        resp_match_o <= acc & cur_bit;
                    end
                end
                ST_CLEAR: begin
                    cnt <= cnt + CNT_W'(1);
                    if (last_word) begin
                        state        <= ST_RESP;
                        resp_valid_o <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    op_ready_o <= 1'b1;
                end
            endcase
        end
    end

    // Membership array: word-wise clear, single-bit set on INSERT hash cycles
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                mem[w] <= '0;
            end
        end else if (clr_en) begin
            mem[clr_sel] <= '0;
        end else if (set_en) begin
            mem[word_sel][bit_sel] <= 1'b1;
        end
    end

`ifdef BLOOM_STATS_EN
    logic [POP_W-1:0] pop_q;

    // Set-bit counter: bumps only when an INSERT flips a 0 bit, saturating
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pop_q <= '0;
        end else if (accept && (op_in == OP_CLEAR)) begin
            pop_q <= '0;
        end else if (set_en && !cur_bit && (pop_q != POP_W'(NUM_BITS))) begin
            pop_q <= pop_q + POP_W'(1);
        end
    end

    assign pop_count_o = pop_q;
`else
    assign pop_count_o = '0;
`endif

endmodule

// File: doc/bloom_filter_unit.md
Name: bloom_filter_unit

Overview:
Bloom-filter responder behind the custom-instruction issue logic. It accepts insert, check and clear commands carrying one 32-bit key from the RS1 operand path. It walks NUM_HASH hash indices sequentially over a NUM_BITS-bit membership array. It returns a one-cycle response with a match flag to the issuing stage.

Parameters:
NUM_BITS, 256, membership array size in bits; power of two, at least 32.
NUM_HASH, 3, hash functions per key; range 1..8.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
op_valid_i  input  1  command request
op_ready_o  output  1  unit can accept a command (IDLE only)
op_i  input  2  bloom_op_e: 00 NOP, 01 INSERT, 10 CHECK, 11 CLEAR
key_i  input  32  key (RS1 data); ignored for NOP and CLEAR
resp_valid_o  output  1  one-cycle response strobe
resp_match_o  output  1  key present (CHECK) or key already present before insert (INSERT); 0 for NOP and CLEAR
pop_count_o  output  $clog2(NUM_BITS+1)  set-bit count (optional feature)

Behaviour:
- Reset values: op_ready_o=1, resp_valid_o=0, resp_match_o=0, pop_count_o=0. Every array bit is 0, FSM in IDLE, hash counter 0.
- Storage: NUM_BITS/32 words of 32 flops. Index IDX_W=$clog2(NUM_BITS). Word select is index[IDX_W-1:5], bit select is index[4:0].
- Hash i: idx_i = ((key ^ SALT[i]) * GOLDEN)[31 -: IDX_W]. The product is 32x32 truncated to the low 32 bits. The key is latched at accept.
- Handshake: a command is accepted when op_valid_i && op_ready_o. op_ready_o=1 only in IDLE. The requester holds its command while ready is low; the unit does not buffer.
- FSM states and transitions:
  - IDLE: accept INSERT or CHECK -> HASH (hash count 0, match accumulator=1). Accept CLEAR -> CLEAR (word count 0). Accept NOP -> RESP.
  - HASH: one index per cycle. Accumulator &= current bit. INSERT also sets the bit in the same cycle. After hash NUM_HASH-1 -> RESP.
  - CLEAR: zero one word per cycle. After word NUM_BITS/32-1 -> RESP.
  - RESP: resp_valid_o=1 for exactly one cycle, resp_match_o=accumulator (0 for NOP/CLEAR) -> IDLE.
- Latency (accept edge to resp_valid_o cycle): INSERT/CHECK = NUM_HASH+1; CLEAR = NUM_BITS/32+1; NOP = 1. No early termination on a CHECK miss.
- resp_match_o is valid only while resp_valid_o=1; it is 0 otherwise.
- Duplicate indices within one key are legal. INSERT reads the pre-set bit value for the accumulator, so a first-time insert whose hashes collide may report 0 or 1 consistently with the bit state at each cycle.
- Back-to-back: a new command may be accepted in the cycle after RESP (IDLE). There is no accept during RESP.
- Reset mid-operation: asynchronous return to IDLE, array cleared, no response issued.

Optional Feature:
BLOOM_STATS_EN defined:
- pop_count_o tracks the number of 1 bits in the array.
- +1 on each INSERT hash cycle that sets a previously-0 bit.
- Zeroed on CLEAR entry.
- Saturates at NUM_BITS.
BLOOM_STATS_EN undefined: the port is present and tied to 0; no counter logic.

Decomposition:
- bloom_pkg: bloom_op_e enum, bloom_state_e enum, GOLDEN=32'h9E3779B1, SALT[0:7] constant array (32'h0, 32'h85EBCA6B, 32'hC2B2AE35, 32'h27D4EB2F, 32'h165667B1, 32'hD3A2646C, 32'hFD7046C5, 32'hB55A4F09).
- Sub-module bloom_hash: combinational key, hash-select -> index. Keeps the multiplier isolated for timing.

Test Plan:
- Reset, then INSERT key 0xDEADBEEF (NUM_BITS=256, NUM_HASH=3) -> ready low for 4 cycles; resp_valid_o on cycle 4, resp_match_o=0; pop_count_o=3 with stats (fewer only on index collision, computed by model).
- CHECK 0xDEADBEEF -> resp on cycle 4, match=1. CHECK 0x00000000 -> match equals reference-model result (expected 0). Re-INSERT 0xDEADBEEF -> match=1, pop_count_o unchanged.
- CLEAR -> ready low 9 cycles, resp on cycle 9 with match=0, pop_count_o=0. A following CHECK 0xDEADBEEF -> match=0.
- op_valid_i held high with a CHECK during a busy INSERT -> not accepted until IDLE; exactly one response per accepted command, in order.
- rst_ni pulsed low at HASH cycle 2 of an INSERT -> no resp_valid_o, ready=1 after release, and a CHECK of the same key returns match=0.
- Random 500 INSERT/CHECK/CLEAR mix against a scoreboard model -> no false negatives, and every response matches model latency and flag.
